// File: rtl/alu_pkg.sv
// Shared ALU definitions: op encoding, widths and the legality check used
// when results are captured.
package alu_pkg;
   localparam int ALU_OP_W = 3;
   localparam int DATA_W   = 32;

   typedef enum logic [ALU_OP_W-1:0] {
      ALU_AND  = 3'd0,
      ALU_OR   = 3'd1,
      ALU_ADD  = 3'd2,
      ALU_SUB  = 3'd3,
      ALU_SLTU = 3'd4
   } alu_op_e;

   function automatic logic op_is_legal(input logic [ALU_OP_W-1:0] op);
      return (op <= ALU_OP_W'(ALU_SLTU));
   endfunction
endpackage

// File: rtl/alu_arbiter_if.sv
// Request, ALU-drive and response channels of the shared-ALU arbiter.
// slave = arbiter side; master = requesters, external ALU and response consumer.
interface alu_arbiter_if #(
   parameter int N_REQ  = 2,
   parameter int DATA_W = alu_pkg::DATA_W,
   parameter int OP_W   = alu_pkg::ALU_OP_W
);
   localparam int ID_W = $clog2(N_REQ);

   logic [N_REQ-1:0]             req_valid;
   logic [N_REQ-1:0]             req_ready;
   logic [N_REQ-1:0][OP_W-1:0]   req_op;
   logic [N_REQ-1:0][DATA_W-1:0] req_a;
   logic [N_REQ-1:0][DATA_W-1:0] req_b;

   logic [OP_W-1:0]   alu_op;
   logic [DATA_W-1:0] alu_a;
   logic [DATA_W-1:0] alu_b;
   logic [DATA_W-1:0] alu_result;

   logic              resp_valid;
   logic              resp_ready;
   logic [ID_W-1:0]   resp_id;
   logic [DATA_W-1:0] resp_result;
   logic              resp_err;

   modport slave (
      input  req_valid, req_op, req_a, req_b, alu_result, resp_ready,
      output req_ready, alu_op, alu_a, alu_b,
             resp_valid, resp_id, resp_result, resp_err
   );

   modport master (
      output req_valid, req_op, req_a, req_b, alu_result, resp_ready,
      input  req_ready, alu_op, alu_a, alu_b,
             resp_valid, resp_id, resp_result, resp_err
   );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr,
// wrapping modulo N. The pointer register lives in the caller.
module rr_arbiter #(
   parameter  int N  = 2,
   localparam int IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] grant_idx
);
   int   idx;
   logic found;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      idx       = 0;
      for (int k = 0; k < N; k++) begin
         idx = (int'(ptr) + k) % N;
         if (!found && req[idx]) begin
            found          = 1'b1;
            grant[idx]     = 1'b1;
            grant_idx      = IW'(idx);
         end
      end
   end
endmodule

// File: rtl/alu_arbiter.sv
// Shares one external combinational ALU among N_REQ requesters round-robin and
// returns each result through a single registered valid/ready response slot.
module alu_arbiter #(
   parameter int N_REQ  = 2,
   parameter int DATA_W = alu_pkg::DATA_W,
   parameter int OP_W   = alu_pkg::ALU_OP_W
) (
   input logic          clk,
   input logic          rst_n,
   alu_arbiter_if.slave bus
);
   import alu_pkg::op_is_legal;

   localparam int ID_W = $clog2(N_REQ);
   localparam logic [0:0] EMPTY = 1'b0;
   localparam logic [0:0] FULL  = 1'b1;

   logic [0:0]        state;
   logic [ID_W-1:0]   ptr;
   logic [ID_W-1:0]   grant_idx;
   logic [N_REQ-1:0]  grant;
   logic              any_grant;
   logic              slot_free;
   logic              accept;
   logic              legal;
   logic [OP_W-1:0]   win_op;
   logic [DATA_W-1:0] win_a;
   logic [DATA_W-1:0] win_b;

   rr_arbiter #(.N(N_REQ)) u_rr (
      .req       (bus.req_valid),
      .ptr       (ptr),
      .grant     (grant),
      .grant_idx (grant_idx)
   );

   // A full slot frees up in the same cycle it drains, giving one op per cycle.
   assign any_grant     = |grant;
   assign slot_free     = (state == EMPTY) || bus.resp_ready;
   assign accept        = any_grant && slot_free;
   assign bus.req_ready = grant & {N_REQ{slot_free}};

   always_comb begin
      win_op = '0;
      win_a  = '0;
      win_b  = '0;
      if (any_grant) begin
         win_op = bus.req_op[grant_idx];
         win_a  = bus.req_a[grant_idx];
         win_b  = bus.req_b[grant_idx];
      end
   end

   assign bus.alu_op     = win_op;
   assign bus.alu_a      = win_a;
   assign bus.alu_b      = win_b;
   assign legal          = op_is_legal(win_op);
   assign bus.resp_valid = (state == FULL);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= EMPTY;
         ptr             <= '0;
         bus.resp_id     <= '0;
         bus.resp_result <= '0;
         bus.resp_err    <= 1'b0;
      end else if (accept) begin
         state           <= FULL;
         bus.resp_id     <= grant_idx;
         bus.resp_result <= legal ? bus.alu_result : '0;
         bus.resp_err    <= !legal;
         ptr             <= (grant_idx == ID_W'(N_REQ-1)) ? '0 : grant_idx + 1'b1;
      end else if (bus.resp_ready) begin
         state <= EMPTY;
      end
   end
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter at N_REQ=2 and N_REQ=3 with a behavioural ALU
// and an expected-response queue per instance.
module tb_alu_arbiter;
   typedef struct packed {
      logic [1:0]  id;
      logic [31:0] res;
      logic        err;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   int   vectors = 0;
   int   errs    = 0;
   exp_t q2[$];
   exp_t q3[$];

   always #5 clk = ~clk;

   alu_arbiter_if #(.N_REQ(2)) if2 ();
   alu_arbiter_if #(.N_REQ(3)) if3 ();

   alu_arbiter #(.N_REQ(2)) u2 (.clk(clk), .rst_n(rst_n), .bus(if2));
   alu_arbiter #(.N_REQ(3)) u3 (.clk(clk), .rst_n(rst_n), .bus(if3));

   function automatic logic [31:0] alu_f(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      case (op)
         3'd0:    return a & b;
         3'd1:    return a | b;
         3'd2:    return a + b;
         3'd3:    return a - b;
         3'd4:    return {31'b0, a < b};
         default: return 32'hDEAD_BEEF;
      endcase
   endfunction

   assign if2.alu_result = alu_f(if2.alu_op, if2.alu_a, if2.alu_b);
   assign if3.alu_result = alu_f(if3.alu_op, if3.alu_a, if3.alu_b);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
      vectors++;
      assert (obs === want) else begin
         errs++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
      end
   endtask

   task automatic push(input bit d3, input int id, input logic [31:0] r, input logic e);
      exp_t x;
      x.id  = 2'(id);
      x.res = r;
      x.err = e;
      if (d3) q3.push_back(x);
      else    q2.push_back(x);
   endtask

   task automatic pop_chk(input string tag, input bit d3);
      exp_t x;
      logic v, e;
      logic [1:0] id;
      logic [31:0] r;
      if (d3) begin
         v = if3.resp_valid; id = if3.resp_id; r = if3.resp_result; e = if3.resp_err;
      end else begin
         v = if2.resp_valid; id = {1'b0, if2.resp_id}; r = if2.resp_result; e = if2.resp_err;
      end
      if ((d3 && q3.size() == 0) || (!d3 && q2.size() == 0)) begin
         vectors++;
         errs++;
         $error("FAIL %s: scoreboard empty, observed id %0d result %0h", tag, id, r);
         return;
      end
      if (d3) x = q3.pop_front();
      else    x = q2.pop_front();
      chk({tag, " valid"},  32'(v),  32'd1);
      chk({tag, " id"},     32'(id), 32'(x.id));
      chk({tag, " result"}, r,       x.res);
      chk({tag, " err"},    32'(e),  32'(x.err));
   endtask

   task automatic set2(input int i, input logic v, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      if2.req_valid[i] = v;
      if2.req_op[i]    = op;
      if2.req_a[i]     = a;
      if2.req_b[i]     = b;
   endtask

   task automatic set3(input int i, input logic v, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      if3.req_valid[i] = v;
      if3.req_op[i]    = op;
      if3.req_a[i]     = a;
      if3.req_b[i]     = b;
   endtask

   initial begin
      rst_n = 1'b0;
      if2.req_valid = '0; if2.req_op = '0; if2.req_a = '0; if2.req_b = '0; if2.resp_ready = 1'b0;
      if3.req_valid = '0; if3.req_op = '0; if3.req_a = '0; if3.req_b = '0; if3.resp_ready = 1'b0;
      #3;
      chk("rst valid",  32'(if2.resp_valid), 32'd0);
      chk("rst id",     32'(if2.resp_id),    32'd0);
      chk("rst result", if2.resp_result,     32'd0);
      chk("rst err",    32'(if2.resp_err),   32'd0);
      chk("rst valid3", 32'(if3.resp_valid), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // single request, same-cycle ready, next-cycle result
      @(negedge clk);
      if2.resp_ready = 1'b1;
      set2(0, 1'b1, 3'd2, 32'd5, 32'd7);
      #1;
      chk("t1 ready",  32'(if2.req_ready), 32'd1);
      chk("t1 alu_op", 32'(if2.alu_op),    32'd2);
      chk("t1 alu_a",  if2.alu_a,          32'd5);
      chk("t1 alu_b",  if2.alu_b,          32'd7);
      push(0, 0, 32'd12, 1'b0);
      @(negedge clk);
      pop_chk("t1 resp", 0);
      set2(0, 1'b0, 3'd0, 32'd0, 32'd0);
      @(negedge clk);
      chk("t1 drain",     32'(if2.resp_valid), 32'd0);
      chk("idle alu_op",  32'(if2.alu_op),     32'd0);
      chk("idle alu_a",   if2.alu_a,           32'd0);

      // pointer is at 1: lone req1 SUB, then contention from pointer 0
      set2(1, 1'b1, 3'd3, 32'd3, 32'd5);
      #1;
      chk("t2 ready1", 32'(if2.req_ready), 32'd2);
      push(0, 1, 32'hFFFF_FFFE, 1'b0);
      @(negedge clk);
      pop_chk("t2 sub", 0);
      set2(0, 1'b1, 3'd0, 32'h0000_F0F0, 32'h0000_FF00);
      set2(1, 1'b1, 3'd1, 32'h0000_000F, 32'h0000_00F0);
      for (int k = 0; k < 4; k++) begin
         if (k > 0) begin
            @(negedge clk);
            pop_chk("t2 resp", 0);
         end
         #1;
         chk("t2 grant", 32'(if2.req_ready), (k % 2 == 0) ? 32'd1 : 32'd2);
         push(0, k % 2, (k % 2 == 0) ? 32'h0000_F000 : 32'h0000_00FF, 1'b0);
      end
      @(negedge clk);
      pop_chk("t2 last", 0);
      set2(0, 1'b0, 3'd0, 32'd0, 32'd0);
      set2(1, 1'b0, 3'd0, 32'd0, 32'd0);
      @(negedge clk);
      chk("t2 drain", 32'(if2.resp_valid), 32'd0);

      // back-pressure: response held while req1 waits
      set2(0, 1'b1, 3'd2, 32'd1, 32'd1);
      #1;
      chk("t3 fill", 32'(if2.req_ready), 32'd1);
      push(0, 0, 32'd2, 1'b0);
      @(negedge clk);
      set2(0, 1'b0, 3'd0, 32'd0, 32'd0);
      set2(1, 1'b1, 3'd3, 32'd10, 32'd3);
      if2.resp_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         #1;
         chk("t3 stall ready", 32'(if2.req_ready),  32'd0);
         chk("t3 hold valid",  32'(if2.resp_valid), 32'd1);
         chk("t3 hold result", if2.resp_result,     32'd2);
         chk("t3 hold id",     32'(if2.resp_id),    32'd0);
         @(negedge clk);
      end
      if2.resp_ready = 1'b1;
      #1;
      chk("t3 release", 32'(if2.req_ready), 32'd2);
      pop_chk("t3 held", 0);
      push(0, 1, 32'd7, 1'b0);
      @(negedge clk);
      pop_chk("t3 req1", 0);
      set2(1, 1'b0, 3'd0, 32'd0, 32'd0);
      @(negedge clk);

      // illegal op and unsigned compare edges, back to back
      set2(0, 1'b1, 3'd6, 32'd9, 32'd9);
      #1;
      chk("t4 ready a", 32'(if2.req_ready), 32'd1);
      push(0, 0, 32'd0, 1'b1);
      @(negedge clk);
      pop_chk("t4 illegal", 0);
      set2(0, 1'b1, 3'd4, 32'hFFFF_FFFF, 32'd1);
      #1;
      chk("t4 ready b", 32'(if2.req_ready), 32'd1);
      push(0, 0, 32'd0, 1'b0);
      @(negedge clk);
      pop_chk("t4 sltu big", 0);
      set2(0, 1'b1, 3'd4, 32'd1, 32'hFFFF_FFFF);
      #1;
      chk("t4 ready c", 32'(if2.req_ready), 32'd1);
      push(0, 0, 32'd1, 1'b0);
      @(negedge clk);
      pop_chk("t4 sltu small", 0);
      set2(0, 1'b0, 3'd0, 32'd0, 32'd0);

      // async reset while FULL and stalled; pointer restarts at 0
      @(negedge clk);
      set2(0, 1'b1, 3'd2, 32'd2, 32'd2);
      #1;
      chk("t5 ready", 32'(if2.req_ready), 32'd1);
      push(0, 0, 32'd4, 1'b0);
      @(negedge clk);
      pop_chk("t5 resp", 0);
      set2(0, 1'b1, 3'd0, 32'h0000_F0F0, 32'h0000_FF00);
      set2(1, 1'b1, 3'd1, 32'h0000_000F, 32'h0000_00F0);
      if2.resp_ready = 1'b0;
      #1;
      chk("t5 stall", 32'(if2.req_ready), 32'd0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t5 async valid",  32'(if2.resp_valid), 32'd0);
      chk("t5 async result", if2.resp_result,     32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      if2.resp_ready = 1'b1;
      #1;
      chk("t5 first winner", 32'(if2.req_ready), 32'd1);
      push(0, 0, 32'h0000_F000, 1'b0);
      @(negedge clk);
      pop_chk("t5 after rst", 0);
      chk("t5 second winner", 32'(if2.req_ready), 32'd2);
      push(0, 1, 32'h0000_00FF, 1'b0);
      @(negedge clk);
      pop_chk("t5 second", 0);
      set2(0, 1'b0, 3'd0, 32'd0, 32'd0);
      set2(1, 1'b0, 3'd0, 32'd0, 32'd0);
      @(negedge clk);
      chk("t5 drain", 32'(if2.resp_valid), 32'd0);

      // N_REQ=3: move pointer to 2, then req2/req0 alternate with wraparound
      if3.resp_ready = 1'b1;
      set3(1, 1'b1, 3'd2, 32'd100, 32'd23);
      #1;
      chk("t6 ready1", 32'(if3.req_ready), 32'd2);
      push(1, 1, 32'd123, 1'b0);
      @(negedge clk);
      pop_chk("t6 r1", 1);
      set3(1, 1'b0, 3'd0, 32'd0, 32'd0);
      set3(2, 1'b1, 3'd3, 32'd8, 32'd1);
      set3(0, 1'b1, 3'd4, 32'd3, 32'd4);
      #1;
      chk("t6 grant", 32'(if3.req_ready), 32'd4);
      push(1, 2, 32'd7, 1'b0);
      for (int k = 1; k < 4; k++) begin
         @(negedge clk);
         pop_chk("t6 resp", 1);
         chk("t6 grant", 32'(if3.req_ready), (k % 2 == 1) ? 32'd1 : 32'd4);
         push(1, (k % 2 == 1) ? 0 : 2, (k % 2 == 1) ? 32'd1 : 32'd7, 1'b0);
      end
      @(negedge clk);
      pop_chk("t6 last", 1);
      if3.resp_ready = 1'b0;
      #1;
      chk("t6 stall", 32'(if3.req_ready), 32'd0);
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         chk("t6 stall ready", 32'(if3.req_ready),  32'd0);
         chk("t6 hold valid",  32'(if3.resp_valid), 32'd1);
         chk("t6 hold id",     32'(if3.resp_id),    32'd0);
      end
      @(negedge clk);
      if3.resp_ready = 1'b1;
      #1;
      chk("t6 ptr held", 32'(if3.req_ready), 32'd4);
      push(1, 2, 32'd7, 1'b0);
      @(negedge clk);
      pop_chk("t6 post stall", 1);
      set3(0, 1'b0, 3'd0, 32'd0, 32'd0);
      set3(2, 1'b0, 3'd0, 32'd0, 32'd0);
      @(negedge clk);
      chk("t6 drain", 32'(if3.resp_valid), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end
endmodule
